// File: rtl/write_bram.sv
// Stream-to-BRAM writer: buffers an input line stream and writes a descriptor's worth of lines to consecutive BRAM addresses.
// Latency: a line pushed at edge t is popped no earlier than edge t+1, so bram_we follows in_valid by at least 2 cycles.
// Backpressure: in_almostfull warns upstream with ALMOSTFULL_SLACK entries free; bram_wready low stalls pops; pushes into a full buffer are dropped (sticky overflow).

// Small synchronous FIFO holding input lines.
// Latency: a pushed line becomes the head one edge later; head is read combinationally.
// Backpressure: none internally; the caller must not push when full without a simultaneous pop, nor pop when empty.
module write_bram_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 8,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Line storage; slots are only read after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // On a full FIFO with push and pop together, wr_ptr equals rd_ptr; the head is
  // read before the edge, so the outgoing line is not disturbed by the incoming one.
  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

module write_bram #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 10,
  parameter int FIFO_DEPTH       = 8,
  parameter int ALMOSTFULL_SLACK = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  output logic                  busy,
  output logic                  op_done,
  output logic                  overflow,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_almostfull,
  input  logic                  bram_wready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [DATA_WIDTH-1:0] bram_wdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [15:0]           offset;
  logic [15:0]           length;
  logic [15:0]           line_cnt;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  logic                  push;
  logic                  pop;
  logic                  latch_cfg;
  logic                  done_nxt;
  logic                  last_line;
  logic [ADDR_WIDTH-1:0] waddr_nxt;

  // A push into a full buffer still fits when the head leaves on the same edge.
  assign push = in_valid && ((fifo_count < CW'(FIFO_DEPTH)) || pop);

  assign in_almostfull = (fifo_count >= CW'(FIFO_DEPTH - ALMOSTFULL_SLACK));

  // The line counter is compared before it increments, so length-1 marks the final pop.
  assign last_line = (line_cnt == (length - 16'd1));

  // 16-bit modulo sum, truncated so the address wraps silently at the top of the BRAM.
  assign waddr_nxt = ADDR_WIDTH'(offset + line_cnt);

  assign busy = (state == ST_WRITE);

  write_bram_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .CW         (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, pop decision and completion strobe.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    latch_cfg = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_start) begin
          latch_cfg = 1'b1;
          if (configreg[31:16] != 16'd0) begin
            state_nxt = ST_WRITE;
          end else begin
            // Empty descriptor: nothing to write, complete right away.
            done_nxt = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (!fifo_empty && bram_wready) begin
          pop = 1'b1;
          if (last_line) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Descriptor capture and line counter; the counter freezes while the BRAM port stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset   <= '0;
      length   <= '0;
      line_cnt <= '0;
    end else if (latch_cfg) begin
      offset   <= configreg[15:0];
      length   <= configreg[31:16];
      line_cnt <= '0;
    end else if (pop) begin
      line_cnt <= line_cnt + 16'd1;
    end
  end

  // Registered BRAM write port; address and data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
    end else begin
      bram_we <= pop;
      if (pop) begin
        bram_waddr <= waddr_nxt;
        bram_wdata <= fifo_head;
      end
    end
  end

  // Completion pulse and sticky drop flag; only reset clears overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      op_done <= done_nxt;
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/write_bram.md
# write_bram

Stream-to-BRAM writer: the write-direction counterpart of the BRAM line reader in the common memory layer. On `op_start` it latches an offset/length descriptor from `configreg`. It drains an internally buffered input line stream into consecutive BRAM addresses and pulses `op_done` after the last line. It sits between a compute or memory-read pipeline stage (upstream, throttled by `in_almostfull`) and one write port of a local BRAM.

## Interface
- `DATA_WIDTH`, 512, BRAM line width in bits
- `ADDR_WIDTH`, 10, BRAM address width (≤16)
- `FIFO_DEPTH`, 8, input buffer depth in lines (power of two, ≥4)
- `ALMOSTFULL_SLACK`, 3, free entries still guaranteed when `in_almostfull` asserts
- `clk` in 1: the block's one clock; all logic on its rising edge
- `reset` in 1: asynchronous, active-high
- `op_start` in 1: start a write operation (honoured only in IDLE)
- `configreg` in 32: [15:0] start offset, [31:16] length in lines
- `busy` out 1: high while in WRITE
- `op_done` out 1: one-cycle completion pulse
- `overflow` out 1: sticky; set when an input line is dropped
- `in_valid` in 1: input line valid
- `in_data` in DATA_WIDTH: input line
- `in_almostfull` out 1: upstream must stop issuing lines
- `bram_wready` in 1: BRAM port available for a write issued next cycle
- `bram_we` out 1: write enable
- `bram_waddr` out ADDR_WIDTH: write address
- `bram_wdata` out DATA_WIDTH: write data

## Operation
- Reset values: `busy`=0, `op_done`=0, `overflow`=0, `bram_we`=0, `bram_waddr`=0, `bram_wdata`=0. The FIFO is emptied, `in_almostfull`=0, and the state is IDLE. Reset mid-operation abandons the operation with no `op_done`.
- FIFO push:
  - `in_valid` pushes `in_data` in any state, so data may arrive before `op_start`.
  - The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the line is dropped and `overflow` is set; only reset clears it.
- `in_almostfull` = (count ≥ FIFO_DEPTH − ALMOSTFULL_SLACK). It is combinational from the registered count.
- State IDLE:
  - On `op_start`, latch offset = configreg[15:0], length = configreg[31:16], and clear the 16-bit line counter.
  - If length ≠ 0, go to WRITE.
  - If length = 0, stay in IDLE and pulse `op_done` the next cycle.
- State WRITE:
  - Each cycle where FIFO is non-empty and `bram_wready`=1: pop the head, and register `bram_we`=1, `bram_waddr` = (offset + counter)[ADDR_WIDTH−1:0], `bram_wdata` = head. Then increment the counter.
  - Otherwise `bram_we`=0, and `bram_waddr`/`bram_wdata` hold their values.
  - When the counter = length−1 at a pop, return to IDLE. `op_done` is asserted in the same cycle as that final `bram_we`.
- `op_start` in WRITE is ignored (no queueing).
- Address arithmetic: 16-bit modulo addition, truncated to ADDR_WIDTH, so it wraps silently at the top of the BRAM.
- Lines beyond `length` stay in the FIFO for the next operation.
- `busy` = (state == WRITE).

## Timing
- All outputs are registered except `in_almostfull`.
- Latency:
  - A line pushed at edge t is poppable at edge t+1.
  - Its `bram_we` is visible after edge t+1, i.e. at least 2 cycles from `in_valid` to `bram_we`.
  - From `op_start` with a pre-filled FIFO, the first `bram_we` comes 2 cycles later (latch, then pop).
- Throughput: 1 line/cycle while the FIFO is non-empty and `bram_wready` is high.
- Upstream contract: it may issue up to ALMOSTFULL_SLACK lines after sampling `in_almostfull`=1 without loss.
- Simultaneous push and pop on a full FIFO: both succeed and the count is unchanged.
- `bram_wready` low freezes the pop and the counter without losing data.

## Test plan
- Basic write: FIFO empty. `op_start` with configreg = 0x0004_0010, then 4 consecutive `in_valid` lines D0..D3 → `bram_we` on 4 consecutive cycles at addresses 0x10..0x13 with D0..D3. `op_done` is coincident with address 0x13, `busy` falls the next cycle, `overflow`=0.
- Pre-buffered and stalled:
  - Push 6 lines in IDLE, then `op_start` with length 6, offset 0.
  - Toggle `bram_wready` 1,0,0,1,…
  - Writes occur only after `bram_wready`=1 cycles, addresses 0..5 in order with no duplicates, and `op_done` comes exactly once.
- Zero length: `op_start` with configreg = 0x0000_0020 → `busy` stays 0, `op_done` pulses one cycle later, no `bram_we`.
- Backpressure/overflow:
  - With `bram_wready`=0, push lines. `in_almostfull` asserts when count = 5 (defaults).
  - Pushing 8 lines leaves `overflow`=0; a 9th push sets `overflow`=1.
- Wrap and leftover data:
  - Offset 0x03FE, length 4, 6 lines supplied → addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - 2 lines remain in the FIFO. A second `op_start` with length 2 at offset 0x40 writes them to 0x40 and 0x41.
- Async reset mid-operation: assert `reset` between clock edges after 2 of 8 writes → all outputs read 0 immediately. After release there are no further writes, `op_done` never pulses, and a fresh operation behaves as in the basic-write test.
